// File: rtl/hit_detector.sv
// Player/enemy overlap detector: one collision pulse per accepted frame hit,
// followed by a frame-counted invulnerability window with a blink request.
module hit_detector #(
    parameter int unsigned INVULN_FRAMES = 60,
    parameter int unsigned BLINK_FRAMES  = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] state,
    input  logic       playerSpriteOn,
    input  logic       enemySpriteOn,
    input  logic       frame_tick,
    input  logic [1:0] hp,
    output logic       collision,
    output logic       invincible,
    output logic       blink,
    output logic [7:0] hit_count
);

    localparam logic [7:0] InvulnLoad = 8'(INVULN_FRAMES);
    localparam logic [7:0] BlinkLoad  = 8'(BLINK_FRAMES);

    typedef enum logic [1:0] {StIdle, StArmed, StHit, StInvuln} fsm_e;

    fsm_e       fsm_q;
    logic       overlap_q;
    logic [7:0] invuln_cnt_q;
    logic [7:0] blink_cnt_q;
    logic       battle;
    logic       overlap;

    assign battle  = (state == 2'd1);
    assign overlap = playerSpriteOn && enemySpriteOn;

    always_ff @(posedge clk) begin
        if (reset) begin
            fsm_q        <= StIdle;
            overlap_q    <= 1'b0;
            invuln_cnt_q <= 8'd0;
            blink_cnt_q  <= 8'd0;
            collision    <= 1'b0;
            invincible   <= 1'b0;
            blink        <= 1'b0;
            hit_count    <= 8'd0;
        end else if (!battle) begin
            // Leaving battle drops any window; hit_count survives.
            fsm_q        <= StIdle;
            overlap_q    <= 1'b0;
            invuln_cnt_q <= 8'd0;
            blink_cnt_q  <= 8'd0;
            collision    <= 1'b0;
            invincible   <= 1'b0;
            blink        <= 1'b0;
        end else begin
            unique case (fsm_q)
                StIdle: begin
                    fsm_q <= StArmed;
                end
                StArmed: begin
                    if (frame_tick) begin
                        overlap_q <= 1'b0;
                        if ((overlap_q || overlap) && (hp != 2'd0)) begin
                            fsm_q        <= StHit;
                            collision    <= 1'b1;
                            invincible   <= 1'b1;
                            blink        <= 1'b1;
                            invuln_cnt_q <= InvulnLoad;
                            blink_cnt_q  <= BlinkLoad;
                            if (hit_count != 8'hFF) begin
                                hit_count <= hit_count + 8'd1;
                            end
                        end
                    end else if (overlap) begin
                        overlap_q <= 1'b1;
                    end
                end
                StHit: begin
                    fsm_q     <= StInvuln;
                    collision <= 1'b0;
                end
                StInvuln: begin
                    overlap_q <= 1'b0;
                    if (frame_tick) begin
                        if (invuln_cnt_q <= 8'd1) begin
                            fsm_q        <= StArmed;
                            invuln_cnt_q <= 8'd0;
                            blink_cnt_q  <= 8'd0;
                            invincible   <= 1'b0;
                            blink        <= 1'b0;
                        end else begin
                            invuln_cnt_q <= invuln_cnt_q - 8'd1;
                            if (blink_cnt_q <= 8'd1) begin
                                blink       <= ~blink;
                                blink_cnt_q <= BlinkLoad;
                            end else begin
                                blink_cnt_q <= blink_cnt_q - 8'd1;
                            end
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hit_detector.sv
// Bench for hit_detector: directed scenarios plus randomized traffic checked
// against a frame-level behavioural model.
module tb_hit_detector;

    localparam int INV   = 60;
    localparam int BLINK = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] st;
    logic       ps;
    logic       es;
    logic       ft;
    logic [1:0] hpv;
    logic       collision;
    logic       invincible;
    logic       blink;
    logic [7:0] hit_count;

    int n_cmp  = 0;
    int n_fail = 0;

    // Model: 0 off, 1 armed, 2 pulse, 3 invulnerable
    int m_phase   = 0;
    bit m_pending = 0;
    int m_window  = 0;
    int m_elapsed = 0;
    int m_hits    = 0;

    hit_detector #(
        .INVULN_FRAMES(INV),
        .BLINK_FRAMES (BLINK)
    ) dut (
        .clk           (clk),
        .reset         (rst),
        .state         (st),
        .playerSpriteOn(ps),
        .enemySpriteOn (es),
        .frame_tick    (ft),
        .hp            (hpv),
        .collision     (collision),
        .invincible    (invincible),
        .blink         (blink),
        .hit_count     (hit_count)
    );

    always #5 clk = ~clk;

    task automatic model_step();
        bit ov;
        ov = ps && es;
        if (rst) begin
            m_phase = 0; m_pending = 0; m_window = 0; m_elapsed = 0; m_hits = 0;
        end else if (st != 2'd1) begin
            m_phase = 0; m_pending = 0; m_window = 0;
        end else begin
            case (m_phase)
                0: m_phase = 1;
                1: begin
                    if (ft) begin
                        if ((m_pending || ov) && hpv != 2'd0) begin
                            m_phase   = 2;
                            m_hits    = (m_hits < 255) ? m_hits + 1 : 255;
                            m_window  = INV;
                            m_elapsed = 0;
                        end
                        m_pending = 0;
                    end else begin
                        m_pending = m_pending || ov;
                    end
                end
                2: m_phase = 3;
                default: begin
                    if (ft) begin
                        m_window  = m_window - 1;
                        m_elapsed = m_elapsed + 1;
                        if (m_window == 0) m_phase = 1;
                    end
                end
            endcase
        end
    endtask

    function automatic logic [10:0] model_out();
        logic inv;
        logic blk;
        inv = (m_phase >= 2);
        blk = inv && (((m_elapsed / BLINK) % 2) == 0);
        return {(m_phase == 2), inv, blk, 8'(m_hits)};
    endfunction

    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [1:0] s, input logic ov, input logic t, input logic [1:0] h);
        st = s; ps = ov; es = ov; ft = t; hpv = h;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_in(2'd0, 1'b0, 1'b0, 2'd3);
        cyc();
        rst = 1'b0;
    endtask

    // Four-cycle frame ending in a tick cycle; returns right after the tick edge.
    task automatic run_frame(input logic ov);
        for (int c = 0; c < 4; c++) begin
            set_in(2'd1, ov, (c == 3), hpv);
            cyc();
        end
        ft = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if ({collision, invincible, blink, hit_count} !== 11'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b required 0", {collision, invincible, blink, hit_count});
        end
    endtask

    task automatic test_single_hit();
        do_reset();
        hpv = 2'd3;
        for (int c = 0; c < 7; c++) begin
            set_in(2'd1, (c == 3), (c == 6), 2'd3);
            cyc();
        end
        set_in(2'd1, 1'b0, 1'b0, 2'd3);
        n_cmp++;
        if ({collision, hit_count, invincible} !== {1'b1, 8'd1, 1'b1}) begin
            n_fail++;
            $display("FAIL single_hit: got col=%b hc=%0d inv=%b required col=1 hc=1 inv=1",
                     collision, hit_count, invincible);
        end
        cyc();
        n_cmp++;
        if ({collision, invincible} !== 2'b01) begin
            n_fail++;
            $display("FAIL single_hit_after: got col=%b inv=%b required col=0 inv=1", collision, invincible);
        end
        n_cmp++;
        if ({collision, invincible, blink, hit_count} !== model_out()) begin
            n_fail++;
            $display("FAIL single_hit_model: got %h required %h",
                     {collision, invincible, blink, hit_count}, model_out());
        end
    endtask

    task automatic test_continuous();
        int pulses;
        int first_f;
        int second_f;
        pulses = 0; first_f = 0; second_f = 0;
        do_reset();
        hpv = 2'd3;
        for (int f = 1; f <= 70; f++) begin
            for (int c = 0; c < 4; c++) begin
                set_in(2'd1, 1'b1, (c == 3), 2'd3);
                cyc();
                if (collision === 1'b1) begin
                    pulses++;
                    if (pulses == 1) first_f = f;
                    if (pulses == 2) second_f = f;
                end
            end
        end
        ft = 1'b0;
        n_cmp++;
        if (pulses != 2 || first_f != 1 || second_f != 62 || hit_count !== 8'd2) begin
            n_fail++;
            $display("FAIL continuous: got pulses=%0d at %0d,%0d hc=%0d required 2 at 1,62 hc=2",
                     pulses, first_f, second_f, hit_count);
        end
    endtask

    task automatic test_blink();
        logic exp_b;
        logic exp_i;
        do_reset();
        hpv = 2'd3;
        run_frame(1'b1);
        n_cmp++;
        if (blink !== 1'b1) begin
            n_fail++;
            $display("FAIL blink_after_hit: got %b required 1", blink);
        end
        for (int t = 1; t <= INV; t++) begin
            run_frame(1'b0);
            exp_i = (t < INV);
            exp_b = exp_i && (((t / BLINK) % 2) == 0);
            n_cmp++;
            if ({blink, invincible} !== {exp_b, exp_i}) begin
                n_fail++;
                $display("FAIL blink_tick%0d: got blink=%b inv=%b required blink=%b inv=%b",
                         t, blink, invincible, exp_b, exp_i);
            end
        end
    endtask

    task automatic test_hp_zero();
        do_reset();
        hpv = 2'd0;
        run_frame(1'b1);
        n_cmp++;
        if ({collision, invincible, hit_count} !== 10'd0) begin
            n_fail++;
            $display("FAIL hp_zero: got col=%b inv=%b hc=%0d required 0 0 0", collision, invincible, hit_count);
        end
        hpv = 2'd3;
        run_frame(1'b0);
        n_cmp++;
        if (collision !== 1'b0) begin
            n_fail++;
            $display("FAIL hp_zero_discard: got col=%b required 0", collision);
        end
        run_frame(1'b1);
        n_cmp++;
        if ({collision, hit_count} !== {1'b1, 8'd1}) begin
            n_fail++;
            $display("FAIL hp_zero_still_armed: got col=%b hc=%0d required 1 1", collision, hit_count);
        end
    endtask

    task automatic test_state_exit();
        do_reset();
        hpv = 2'd3;
        run_frame(1'b1);
        for (int i = 0; i < 10; i++) run_frame(1'b0);
        n_cmp++;
        if (invincible !== 1'b1) begin
            n_fail++;
            $display("FAIL exit_pre: got inv=%b required 1", invincible);
        end
        set_in(2'd0, 1'b0, 1'b0, 2'd3);
        cyc();
        n_cmp++;
        if ({collision, invincible, blink, hit_count} !== {3'b000, 8'd1}) begin
            n_fail++;
            $display("FAIL exit_idle: got col=%b inv=%b blink=%b hc=%0d required 0 0 0 1",
                     collision, invincible, blink, hit_count);
        end
        run_frame(1'b1);
        n_cmp++;
        if ({collision, hit_count} !== {1'b1, 8'd2}) begin
            n_fail++;
            $display("FAIL exit_rehit: got col=%b hc=%0d required 1 2", collision, hit_count);
        end
    endtask

    task automatic test_reset_invuln();
        int seen;
        seen = 0;
        do_reset();
        hpv = 2'd3;
        run_frame(1'b1);
        for (int i = 0; i < 5; i++) run_frame(1'b0);
        rst = 1'b1;
        set_in(2'd1, 1'b1, 1'b0, 2'd3);
        cyc();
        n_cmp++;
        if ({collision, invincible, blink, hit_count} !== 11'd0) begin
            n_fail++;
            $display("FAIL reset_invuln: got %b required 0", {collision, invincible, blink, hit_count});
        end
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            set_in(2'd1, 1'b0, 1'b0, 2'd3);
            cyc();
            if (collision === 1'b1) seen++;
        end
        n_cmp++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL reset_no_pulse: got %0d pulses required 0", seen);
        end
        run_frame(1'b1);
        n_cmp++;
        if ({collision, hit_count} !== {1'b1, 8'd1}) begin
            n_fail++;
            $display("FAIL reset_rehit: got col=%b hc=%0d required 1 1", collision, hit_count);
        end
    endtask

    task automatic test_random();
        int gap;
        int bad;
        bad = 0;
        gap = 3;
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            rst = ($urandom_range(0, 399) == 0);
            st  = ($urandom_range(0, 99) < 2) ? 2'($urandom_range(0, 3)) : 2'd1;
            ps  = ($urandom_range(0, 9) < 3);
            es  = ($urandom_range(0, 9) < 5);
            hpv = ($urandom_range(0, 9) < 2) ? 2'd0 : 2'($urandom_range(1, 3));
            if (gap == 0) begin
                ft  = 1'b1;
                gap = $urandom_range(1, 5);
            end else begin
                ft  = 1'b0;
                gap = gap - 1;
            end
            cyc();
            n_cmp++;
            if ({collision, invincible, blink, hit_count} !== model_out()) begin
                n_fail++;
                if (bad < 10) begin
                    $display("FAIL random_cycle%0d: got %h required %h", i,
                             {collision, invincible, blink, hit_count}, model_out());
                end
                bad++;
            end
        end
        rst = 1'b0;
        ft  = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        set_in(2'd0, 1'b0, 1'b0, 2'd3);
        test_reset();
        test_single_hit();
        test_continuous();
        test_blink();
        test_hp_zero();
        test_state_exit();
        test_reset_invuln();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
